result_fifo: RTL and testbench
==============================

# result_fifo

Buffers the 5-bit results produced by the four-operand capture/compute stage, which sits directly upstream. Each new `valid` assertion from that stage is turned into exactly one FIFO write. The block keeps running min/max statistics over accepted results. It presents a pop-on-request read port to the downstream consumer (display driver or host readout).

## Interface
Parameters:
- `DEPTH`, default 4: number of entries; power of two, 2..16. `AW` = log2(`DEPTH`).

Ports:
- `clock`  in  1  sole clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `result_in`  in  5  result word from the upstream compute stage
- `valid_in`  in  1  upstream valid; a level signal that may stay high for many cycles
- `clr`  in  1  synchronous clear of FIFO, flags and statistics
- `rd_en`  in  1  pop request, sampled each rising edge
- `rd_data`  out  5  registered data of the last accepted pop
- `rd_valid`  out  1  one-cycle pulse marking new `rd_data`
- `count`  out  `AW`+1  number of stored entries, 0..`DEPTH`
- `empty`  out  1  high when `count` == 0
- `full`  out  1  high when `count` == `DEPTH`
- `overflow`  out  1  sticky; a write event was dropped because the FIFO was full
- `max_val`  out  5  largest accepted result since reset/clear
- `min_val`  out  5  smallest accepted result since reset/clear
- `stats_valid`  out  1  at least one result accepted since reset/clear

## Operation
- Edge detect: register `valid_d` <= `valid_in` every cycle, including during `clr`.
- Write event: `wr_ev` = `valid_in` & ~`valid_d`. Only a rising edge produces a write, so one write per upstream assertion.
- Storage is a circular buffer: `wr_ptr` and `rd_ptr` of width `AW`, plus an occupancy counter of width `AW`+1. Pointers wrap modulo `DEPTH`.
- Accepted write (`wr_ev` and (not full, or pop accepted in the same cycle)):
  - store `result_in` at `wr_ptr`; increment `wr_ptr`.
  - update stats: `max_val` = max(`max_val`, `result_in`), `min_val` = min(`min_val`, `result_in`), `stats_valid` = 1.
  - On the first accepted write after reset/clear, both `max_val` and `min_val` take `result_in`.
- Dropped write (`wr_ev`, full, no pop in the same cycle): data is discarded, `overflow` is set, stats are unchanged.
- Accepted pop (`rd_en` and not empty): `rd_data` <= mem[`rd_ptr`]; increment `rd_ptr`; `rd_valid` is 1 for the following cycle.
- Ignored pop (`rd_en` while empty): no state change; `rd_valid` = 0; `rd_data` holds its value.
- Simultaneous accepted write and pop: `count` is unchanged.
  - When full, the pop frees the slot and the write is accepted; no overflow.
  - When empty, the pop is ignored and the write is accepted; `count` becomes 1. There is no fall-through.
- Arithmetic: min/max are unsigned 5-bit compares. `count` never exceeds `DEPTH` and never underflows.
- `clr` has priority over writes and pops in the same cycle. It sets:
  - pointers and `count` to 0
  - `overflow`, `rd_valid` and `stats_valid` to 0
  - `max_val` to 0 and `min_val` to 5'h1F
  - `rd_data` and memory contents are left unchanged.
- Reset values:
  - `rd_data` 0, `rd_valid` 0, `count` 0, `empty` 1, `full` 0, `overflow` 0
  - `max_val` 0, `min_val` 5'h1F, `stats_valid` 0
  - internal pointers 0, `valid_d` 0
  - Memory contents are don't-care.

## Timing
- Write latency: a rising edge of `valid_in` sampled at edge N updates `count`, `empty`, `full` and stats after edge N.
- Pop latency: `rd_en` sampled at edge M gives `rd_data` and `rd_valid` valid after edge M, for one cycle only.
- `empty`, `full` and `count` are derived from registered state only. No combinational path from `rd_en`, `valid_in` or `clr` to any output.
- Back-to-back pops on consecutive cycles give one entry per cycle; `rd_valid` stays high continuously.
- Upstream write events occur at most every other cycle (a valid rise needs a preceding low cycle). Any pattern must still be handled.
- `valid_in` already high at the first edge after `rst` deasserts counts as a rising edge (`valid_d` resets to 0).
- `rst` asserted mid-operation clears all state immediately, without waiting for a clock edge. Entries in flight are lost.
- `valid_in` held high through a `clr` does not produce a write after `clr` drops; a new rising edge is required.

## Test plan
- Reset, then pulse `valid_in` with `result_in` = 9, 3, 17, 30 (one-cycle highs separated by lows) → `count` = 4, `full` = 1, `max_val` = 30, `min_val` = 3, `stats_valid` = 1.
- Hold `valid_in` high for 5 cycles with `result_in` = 7 → exactly one write; `count` increments by 1.
- Fill with 1, 2, 3, 4, then send a fifth rising edge with value 5 → `overflow` = 1, `count` = 4, `max_val` = 4. Four pops return 1, 2, 3, 4 in order, each with a one-cycle `rd_valid`. A fifth pop gives `rd_valid` = 0 and `rd_data` holds 4.
- Full FIFO (1, 2, 3, 4): `rd_en` in the same cycle as a `valid_in` rising edge with value 6 → `rd_data` = 1, `count` = 4, `overflow` = 0. Draining returns 2, 3, 4, 6; the 6 is the pointer wrap-around entry.
- With 2 entries stored and `overflow` = 1, assert `clr` together with `rd_en` and a valid rise → next cycle: `count` = 0, `empty` = 1, `overflow` = 0, `rd_valid` = 0, `stats_valid` = 0, `min_val` = 31, `max_val` = 0.
- Assert `rst` asynchronously between edges with 3 entries stored → all outputs take their reset values before the next clock edge.

Source files
------------

// File: rtl/result_fifo.sv
// result_fifo
//   Buffers 5-bit results from the upstream capture/compute stage. Each rising
//   edge of valid_in is one write attempt; the block keeps running min/max
//   statistics over accepted results and offers a pop-on-request read port.
//
// Ports:
//   clock       - sole clock, rising edge
//   rst         - asynchronous active-high reset
//   result_in   - result word from upstream
//   valid_in    - upstream valid level (only its rising edge writes)
//   clr         - synchronous clear of FIFO, flags and statistics (top priority)
//   rd_en       - pop request
//   rd_data     - registered data of the last accepted pop
//   rd_valid    - one-cycle pulse marking new rd_data
//   count       - stored entries, 0..DEPTH
//   empty/full  - occupancy flags from registered count
//   overflow    - sticky: a write was dropped because the FIFO was full
//   max_val     - largest accepted result since reset/clear
//   min_val     - smallest accepted result since reset/clear
//   stats_valid - at least one result accepted since reset/clear
module result_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          rst,
  input  logic [4:0]    result_in,
  input  logic          valid_in,
  input  logic          clr,
  input  logic          rd_en,
  output logic [4:0]    rd_data,
  output logic          rd_valid,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic [4:0]    max_val,
  output logic [4:0]    min_val,
  output logic          stats_valid
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [4:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          valid_d;

  logic wr_ev;
  logic pop_ok;
  logic wr_ok;
  logic wr_drop;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  assign wr_ev  = valid_in & ~valid_d;
  assign pop_ok = rd_en & ~empty & ~clr;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
  assign wr_ok   = wr_ev & ~clr & (~full | pop_ok);
  assign wr_drop = wr_ev & ~clr & full & ~pop_ok;

  // Edge detector keeps tracking through clr so a level held across clr
  // does not look like a fresh rise afterwards.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) valid_d <= 1'b0;
    else     valid_d <= valid_in;
  end

  // Storage has no reset; clr leaves contents untouched.
  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr] <= result_in;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop_ok;
      if (pop_ok) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (wr_drop) overflow <= 1'b1;
      case ({wr_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      max_val     <= '0;
      min_val     <= '1;
      stats_valid <= 1'b0;
    end else if (clr) begin
      max_val     <= '0;
      min_val     <= '1;
      stats_valid <= 1'b0;
    end else if (wr_ok) begin
      stats_valid <= 1'b1;
      // First accepted write seeds both extremes regardless of prior values.
      if (!stats_valid || (result_in > max_val)) max_val <= result_in;
      if (!stats_valid || (result_in < min_val)) min_val <= result_in;
    end
  end

endmodule

// File: tb/tb_result_fifo.sv
// tb_result_fifo
//   Directed plus random stimulus for result_fifo, checked every cycle against
//   a queue-based reference model and at key points against fixed values.
module tb_result_fifo;

  localparam int DEPTH = 4;
  localparam int AW = $clog2(DEPTH);

  logic          clk;
  logic          rst;
  logic [4:0]    result_in;
  logic          valid_in;
  logic          clr;
  logic          rd_en;
  logic [4:0]    rd_data;
  logic          rd_valid;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic [4:0]    max_val;
  logic [4:0]    min_val;
  logic          stats_valid;

  result_fifo #(.DEPTH(DEPTH)) dut (
    .clock       (clk),
    .rst         (rst),
    .result_in   (result_in),
    .valid_in    (valid_in),
    .clr         (clr),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .overflow    (overflow),
    .max_val     (max_val),
    .min_val     (min_val),
    .stats_valid (stats_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [4:0] q[$];
  bit         m_prev;
  bit         m_ovf;
  bit         m_rv;
  logic [4:0] m_rdd;
  logic [4:0] m_max;
  logic [4:0] m_min;
  bit         m_sv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_prev = 0; m_ovf = 0; m_rv = 0; m_rdd = 5'd0;
    m_max = 5'd0; m_min = 5'd31; m_sv = 0;
  endtask

  task automatic model_edge(input bit v, input logic [4:0] r, input bit rd, input bit c);
    bit rise;
    rise = v && !m_prev;
    m_prev = v;
    if (c) begin
      q.delete();
      m_ovf = 0; m_rv = 0; m_sv = 0; m_max = 5'd0; m_min = 5'd31;
      return;
    end
    m_rv = rd && (q.size() > 0);
    if (m_rv) m_rdd = q.pop_front();
    if (rise) begin
      if (q.size() < DEPTH) begin
        q.push_back(r);
        if (!m_sv) begin
          m_max = r; m_min = r;
        end else begin
          if (r > m_max) m_max = r;
          if (r < m_min) m_min = r;
        end
        m_sv = 1;
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rd_data"},     rd_data,     m_rdd);
    check({tag, ".rd_valid"},    rd_valid,    m_rv);
    check({tag, ".count"},       count,       q.size());
    check({tag, ".empty"},       empty,       q.size() == 0);
    check({tag, ".full"},        full,        q.size() == DEPTH);
    check({tag, ".overflow"},    overflow,    m_ovf);
    check({tag, ".max_val"},     max_val,     m_max);
    check({tag, ".min_val"},     min_val,     m_min);
    check({tag, ".stats_valid"}, stats_valid, m_sv);
  endtask

  task automatic cyc(input string tag, input bit v, input logic [4:0] r, input bit rd, input bit c);
    valid_in = v; result_in = r; rd_en = rd; clr = c;
    model_edge(v, r, rd, c);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic pulse(input string tag, input logic [4:0] r);
    cyc(tag, 1, r, 0, 0);
    cyc(tag, 0, r, 0, 0);
  endtask

  initial begin
    rst = 1'b0; valid_in = 0; result_in = '0; clr = 0; rd_en = 0;
    model_reset();
    #2 rst = 1'b1;
    #2;
    check_all("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Four one-cycle pulses fill the FIFO
    pulse("fill", 5'd9); pulse("fill", 5'd3); pulse("fill", 5'd17); pulse("fill", 5'd30);
    check("tp1.count", count, 4);
    check("tp1.full", full, 1);
    check("tp1.max", max_val, 30);
    check("tp1.min", min_val, 3);
    check("tp1.sv", stats_valid, 1);

    // Long valid level yields a single write
    cyc("pop9", 0, 5'd0, 1, 0);
    check("tp2.pop_data", rd_data, 9);
    for (int i = 0; i < 5; i++) cyc("hold", 1, 5'd7, 0, 0);
    cyc("hold_end", 0, 5'd7, 0, 0);
    check("tp2.count", count, 4);
    check("tp2.ovf", overflow, 0);

    // Overflow then in-order drain
    cyc("clr1", 0, 5'd0, 0, 1);
    pulse("f", 5'd1); pulse("f", 5'd2); pulse("f", 5'd3); pulse("f", 5'd4);
    pulse("drop", 5'd5);
    check("tp3.ovf", overflow, 1);
    check("tp3.count", count, 4);
    check("tp3.max", max_val, 4);
    for (int i = 1; i <= 4; i++) begin
      cyc("drain", 0, 5'd0, 1, 0);
      check("tp3.rd_data", rd_data, i);
      check("tp3.rd_valid", rd_valid, 1);
    end
    cyc("empty_pop", 0, 5'd0, 1, 0);
    check("tp3.idle_valid", rd_valid, 0);
    check("tp3.idle_data", rd_data, 4);

    // Pop and write together on a full FIFO, then drain across the wrap
    cyc("clr2", 0, 5'd0, 0, 1);
    pulse("f", 5'd1); pulse("f", 5'd2); pulse("f", 5'd3); pulse("f", 5'd4);
    cyc("swap", 1, 5'd6, 1, 0);
    check("tp4.rd_data", rd_data, 1);
    check("tp4.count", count, 4);
    check("tp4.ovf", overflow, 0);
    cyc("swap_lo", 0, 5'd6, 0, 0);
    for (int i = 0; i < 4; i++) begin
      logic [4:0] exp_d [4] = '{5'd2, 5'd3, 5'd4, 5'd6};
      cyc("wrap", 0, 5'd0, 1, 0);
      check("tp4.wrap_data", rd_data, exp_d[i]);
    end

    // Write into empty with simultaneous pop: no fall-through
    cyc("empty_wr", 1, 5'd11, 1, 0);
    check("fall.rd_valid", rd_valid, 0);
    check("fall.count", count, 1);
    cyc("empty_wr_lo", 0, 5'd0, 0, 0);

    // clr beats pop and write in the same cycle
    cyc("clr3", 0, 5'd0, 0, 1);
    pulse("f", 5'd1); pulse("f", 5'd2); pulse("f", 5'd3); pulse("f", 5'd4); pulse("f", 5'd5);
    cyc("p", 0, 5'd0, 1, 0);
    cyc("p", 0, 5'd0, 1, 0);
    check("tp5.pre_count", count, 2);
    check("tp5.pre_ovf", overflow, 1);
    cyc("clr_all", 1, 5'd9, 1, 1);
    check("tp5.count", count, 0);
    check("tp5.empty", empty, 1);
    check("tp5.ovf", overflow, 0);
    check("tp5.rd_valid", rd_valid, 0);
    check("tp5.sv", stats_valid, 0);
    check("tp5.min", min_val, 31);
    check("tp5.max", max_val, 0);
    cyc("held_thru_clr", 1, 5'd9, 0, 0);
    check("clr_hold.count", count, 0);
    cyc("held_lo", 0, 5'd9, 0, 0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc("rand", $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
          $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0);
    end

    // Asynchronous reset between edges with 3 entries stored
    cyc("clr4", 0, 5'd0, 0, 1);
    pulse("f", 5'd20); pulse("f", 5'd21); pulse("f", 5'd22);
    check("tp6.pre_count", count, 3);
    rst = 1'b1;
    #3;
    model_reset();
    check_all("async_rst");
    check("tp6.count", count, 0);
    check("tp6.empty", empty, 1);
    check("tp6.min", min_val, 31);
    @(posedge clk); #1;
    valid_in = 1; result_in = 5'd12;
    rst = 1'b0;
    // valid already high at the first edge after reset counts as a rise
    cyc("post_rst", 1, 5'd12, 0, 0);
    check("post_rst.count", count, 1);
    check("post_rst.max", max_val, 12);
    cyc("post_rst_lo", 0, 5'd0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
